// File: rtl/serial_paralelo.sv
// -----------------------------------------------------------------------------
// serial_paralelo
//
// Purpose:
//   Serial-to-parallel receive stage. Samples a 1-bit MSB-first stream on
//   clk_32f and looks for COM symbols (8'hBC) to find byte alignment.
//   COM_COUNT consecutive aligned COMs establish lock (ACTIVE). In ACTIVE, every
//   received byte is presented on data_out with a one-cycle byte_strobe.
//   valid_out marks non-COM bytes, so COM bytes act as idle fill.
//
// Optional feature (macro SP_LOSS_OF_SYNC_EN):
//   When defined, LOS_COUNT consecutive all-zero bytes in ACTIVE drop lock
//   back to SEARCH. When undefined, ACTIVE is left only through reset.
//
// Ports:
//   clk_32f     in   bit clock; all logic runs on its rising edge
//   reset       in   synchronous, active-low (0 = reset, 1 = run)
//   data_in     in   serial bit, MSB of each byte first
//   data_out    out  [7:0] last byte received in ACTIVE, held between strobes
//   valid_out   out  1 when data_out is a non-COM byte
//   byte_strobe out  one-cycle pulse when data_out/valid_out update
//   active      out  1 while locked (state ACTIVE)
// -----------------------------------------------------------------------------
module serial_paralelo #(
    parameter int COM_COUNT = 4
`ifdef SP_LOSS_OF_SYNC_EN
    ,
    parameter int LOS_COUNT = 4
`endif
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [7:0] COM_SYMBOL = 8'hBC;
    localparam logic [4:0] COM_TARGET = 5'(COM_COUNT);
`ifdef SP_LOSS_OF_SYNC_EN
    localparam logic [4:0] LOS_TARGET = 5'(LOS_COUNT);
`endif

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ALIGN,
        ST_ACTIVE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  bc_cnt_q, bc_cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        byte_strobe_q, byte_strobe_d;
    logic        active_q, active_d;
`ifdef SP_LOSS_OF_SYNC_EN
    logic [3:0]  los_cnt_q, los_cnt_d;
    logic [3:0]  los_inc;
`endif

    logic [7:0]  win;
    logic        win_is_com;
    logic        boundary;
    logic [3:0]  bc_inc;

    always_comb begin
        // The window already includes the bit being sampled on this edge.
        win        = {sr_q[6:0], data_in};
        win_is_com = (win == COM_SYMBOL);
        boundary   = (bit_cnt_q == 3'd7);
        bc_inc     = (bc_cnt_q == 4'hF) ? 4'hF : bc_cnt_q + 4'd1;
`ifdef SP_LOSS_OF_SYNC_EN
        los_inc    = (los_cnt_q == 4'hF) ? 4'hF : los_cnt_q + 4'd1;
        los_cnt_d  = los_cnt_q;
`endif

        sr_d          = win;
        bit_cnt_d     = bit_cnt_q + 3'd1;   // wraps 7 -> 0 on its own
        bc_cnt_d      = bc_cnt_q;
        state_d       = state_q;
        data_out_d    = data_out_q;
        valid_out_d   = valid_out_q;
        byte_strobe_d = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                // Bit-by-bit hunt; the byte counter stays parked at 0 so a
                // found COM puts the next bit at position 0.
                bit_cnt_d = 3'd0;
                if (win_is_com) begin
                    bc_cnt_d = 4'd1;
                    state_d  = (COM_COUNT == 1) ? ST_ACTIVE : ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (boundary) begin
                    if (win_is_com) begin
                        if ({1'b0, bc_cnt_q} + 5'd1 == COM_TARGET) begin
                            state_d = ST_ACTIVE;
                        end else begin
                            bc_cnt_d = bc_inc;
                        end
                    end else begin
                        // Misaligned byte: restart the hunt from the next bit.
                        state_d  = ST_SEARCH;
                        bc_cnt_d = 4'd0;
                    end
                end
            end

            ST_ACTIVE: begin
                if (boundary) begin
                    data_out_d    = win;
                    valid_out_d   = !win_is_com;
                    byte_strobe_d = 1'b1;
`ifdef SP_LOSS_OF_SYNC_EN
                    if (win == 8'h00) begin
                        if ({1'b0, los_cnt_q} + 5'd1 >= LOS_TARGET) begin
                            // Lock lost: this zero byte is swallowed.
                            state_d       = ST_SEARCH;
                            data_out_d    = data_out_q;
                            valid_out_d   = 1'b0;
                            byte_strobe_d = 1'b0;
                            bc_cnt_d      = 4'd0;
                            los_cnt_d     = 4'd0;
                            bit_cnt_d     = 3'd0;
                        end else begin
                            los_cnt_d = los_inc;
                        end
                    end else begin
                        los_cnt_d = 4'd0;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_SEARCH;
            end
        endcase

        active_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q       <= ST_SEARCH;
            sr_q          <= 8'h00;
            bit_cnt_q     <= 3'd0;
            bc_cnt_q      <= 4'd0;
            data_out_q    <= 8'h00;
            valid_out_q   <= 1'b0;
            byte_strobe_q <= 1'b0;
            active_q      <= 1'b0;
`ifdef SP_LOSS_OF_SYNC_EN
            los_cnt_q     <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            bc_cnt_q      <= bc_cnt_d;
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            byte_strobe_q <= byte_strobe_d;
            active_q      <= active_d;
`ifdef SP_LOSS_OF_SYNC_EN
            los_cnt_q     <= los_cnt_d;
`endif
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_out_q;
    assign byte_strobe = byte_strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo
//
// Self-checking bench for serial_paralelo (COM_COUNT = 4, LOS_COUNT = 4).
// Bytes are shifted in MSB-first, one bit per clock. When a byte is driven
// that should be presented, its expected value/valid pair is queued. Every
// strobe seen on the output pops the queue and is compared. Between strobes,
// data_out must hold and strobes must be exactly 8 cycles apart.
// -----------------------------------------------------------------------------
module tb_serial_paralelo;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         gap    = -1;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] com = 8'hBC;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    // Drive one bit, let one rising edge pass, then sample and score.
    task automatic tick(input logic b);
        logic rst_now;
        exp_t e;
        data_in = b;
        rst_now = reset;
        @(posedge clk_32f);
        #1;
        if (byte_strobe === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: data_out=%h valid_out=%b, no byte expected",
                         data_out, valid_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.data || valid_out !== e.valid) begin
                    errors++;
                    $display("FAIL strobe_data: got data_out=%h valid_out=%b, expected %h/%b",
                             data_out, valid_out, e.data, e.valid);
                end else begin
                    $display("strobe ok: data_out=%h valid_out=%b", data_out, valid_out);
                end
            end
            if (gap >= 0) begin
                checks++;
                if (gap != 7) begin
                    errors++;
                    $display("FAIL strobe_spacing: got %0d idle cycles, expected 7", gap);
                end
            end
            gap = 0;
        end else begin
            if (rst_now) begin
                checks++;
                if (data_out !== prev_data) begin
                    errors++;
                    $display("FAIL data_hold: data_out=%h changed without strobe, expected %h",
                             data_out, prev_data);
                end
            end
            if (gap >= 0) gap++;
        end
        if (!rst_now) gap = -1;
        prev_data = data_out;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit exp_strobe);
        exp_t e;
        if (exp_strobe) begin
            e.data  = v;
            e.valid = (v != 8'hBC);
            exp_q.push_back(e);
        end
        for (int i = 7; i >= 0; i--) tick(v[i]);
    endtask

    task automatic check_active(input logic exp, input string name);
        checks++;
        if (active !== exp) begin
            errors++;
            $display("FAIL %s: active=%b, expected %b", name, active, exp);
        end else begin
            $display("%s: active=%b", name, active);
        end
    endtask

    task automatic expect_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected strobes never arrived, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick(1'($urandom_range(1, 0)));
        tick(1'($urandom_range(1, 0)));
        reset = 1'b1;
    endtask

    task automatic lock();
        for (int k = 0; k < 4; k++) send_byte(8'hBC, 1'b0);
        check_active(1'b1, "lock_acquired");
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1'($urandom_range(1, 0)));
            checks++;
            if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0 || byte_strobe !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: data_out=%h valid=%b active=%b strobe=%b, expected 00/0/0/0",
                         data_out, valid_out, active, byte_strobe);
            end else begin
                $display("reset cycle %0d: outputs cleared", k);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_lock();
        apply_reset();
        tick(1'b1); tick(1'b0); tick(1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0);
        for (int i = 7; i >= 1; i--) tick(com[i]);
        check_active(1'b0, "lock_before_last_bit");
        tick(com[0]);
        check_active(1'b1, "lock_after_last_bit");
        send_byte(8'h5A, 1'b1);
        send_byte(8'hBC, 1'b1);
        tick(1'b0);
        expect_drained("lock_drain");
    endtask

    task automatic test_failed_align();
        apply_reset();
        send_byte(8'hBC, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'h3C, 1'b0);
        check_active(1'b0, "align_broken_by_3c");
        for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0);
        check_active(1'b0, "align_three_more_bc");
        send_byte(8'hBC, 1'b0);
        check_active(1'b1, "align_relocked");
        send_byte(8'hA5, 1'b1);
        tick(1'b0);
        expect_drained("align_drain");
    endtask

    task automatic test_data_stream();
        apply_reset();
        lock();
        for (int v = 0; v < 16; v++) send_byte(8'(v), 1'b1);
        tick(1'b0);
        expect_drained("stream_drain");
    endtask

    task automatic test_reset_mid_byte();
        apply_reset();
        lock();
        send_byte(8'h81, 1'b1);
        tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b1);
        reset = 1'b0;
        tick(1'b0);
        checks++;
        if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0 || byte_strobe !== 1'b0) begin
            errors++;
            $display("FAIL midbyte_reset: data_out=%h valid=%b active=%b strobe=%b, expected 00/0/0/0",
                     data_out, valid_out, active, byte_strobe);
        end
        reset = 1'b1;
        expect_drained("midbyte_before_relock");
        for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0);
        send_byte(8'h77, 1'b0);
        check_active(1'b0, "midbyte_partial_relock");
        lock();
        send_byte(8'h5A, 1'b1);
        tick(1'b0);
        expect_drained("midbyte_drain");
    endtask

    task automatic test_loss_of_sync();
        apply_reset();
        lock();
        for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b1);
`ifdef SP_LOSS_OF_SYNC_EN
        send_byte(8'h00, 1'b0);
        check_active(1'b0, "los_dropped");
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL los_valid: valid_out=%b, expected 0", valid_out);
        end
`else
        send_byte(8'h00, 1'b1);
        check_active(1'b1, "los_sticky");
`endif
        tick(1'b0);
        expect_drained("los_drain");
    endtask

    initial begin
        test_reset();
        test_lock();
        test_failed_align();
        test_data_stream();
        test_reset_mid_byte();
        test_loss_of_sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Receive-side stage directly downstream of the parallel-to-serial transmitter.
- Samples the 1-bit serial stream MSB-first on clk_32f.
- Acquires byte alignment by finding COM symbols (8'hBC), then outputs 8-bit bytes with a valid flag.
- COM bytes are idle and are never marked valid.
- Feeds the byte-wide receive logic that runs at clk_4f (phase-aligned, 1/8 rate).

Parameters:
- COM_COUNT, 4: consecutive aligned 8'hBC bytes required before declaring lock (range 1..15).
- LOS_COUNT, 4: consecutive all-zero bytes that drop lock; used only with SP_LOSS_OF_SYNC_EN (range 1..15).

Ports:
- clk_32f  input  1  bit clock; all logic on posedge.
- reset  input  1  synchronous, active-low; 0 = reset, 1 = run.
- data_in  input  1  serial bit, MSB of each byte first; upstream changes it on negedge, so it is stable at posedge.
- data_out  output  8  last received byte in ACTIVE; held for 8 cycles.
- valid_out  output  1  1 when data_out is a non-COM byte; held with data_out.
- byte_strobe  output  1  one-cycle pulse on the cycle data_out/valid_out update.
- active  output  1  1 while state is ACTIVE (lock achieved).

Behaviour:
- Reset (reset==0 at posedge), all registers cleared:
  - shift reg = 0, bit_cnt = 0, bc_cnt = 0, state = SEARCH.
  - data_out = 8'h00, valid_out = 0, byte_strobe = 0, active = 0.
- Reset mid-operation takes effect at the next posedge and discards any partial byte.
- Window: every posedge, win = {sr[6:0], data_in}, then sr <= win.
- The 3-bit bit_cnt increments every cycle outside SEARCH and wraps 7->0. A byte boundary is bit_cnt==7.
- SEARCH:
  - if win==8'hBC: bit_cnt<=0, bc_cnt<=1, next state ALIGN; if COM_COUNT==1, next state is ACTIVE instead.
  - otherwise stay in SEARCH, bit_cnt held at 0.
- ALIGN, at a boundary only:
  - win==8'hBC and bc_cnt+1==COM_COUNT: go to ACTIVE.
  - win==8'hBC otherwise: bc_cnt++.
  - win!=8'hBC: go to SEARCH, bc_cnt<=0; this same win is not re-examined for BC.
  - Non-boundary cycles: no state change.
- ACTIVE:
  - active=1, registered, rising on the posedge that enters ACTIVE.
  - At each boundary: data_out<=win, valid_out<=(win!=8'hBC), byte_strobe<=1.
  - Otherwise byte_strobe<=0 and data_out/valid_out hold.
  - The lock-completing COM byte itself produces no strobe. The first strobe is for the byte after it.
  - Without SP_LOSS_OF_SYNC_EN, ACTIVE is left only by reset.
- Latency: the last bit of a byte sampled at posedge N appears on data_out/valid_out/byte_strobe after posedge N (registered at N).
- Counters: bc_cnt and los_cnt are 4-bit and saturate at 15. No wrap is possible within the legal parameter range.
- Simultaneous events: reset has priority over all state activity.

Optional Feature:
- SP_LOSS_OF_SYNC_EN defined:
  - In ACTIVE, los_cnt counts consecutive boundary bytes equal to 8'h00; any other byte clears it.
  - When the LOS_COUNT-th consecutive zero byte is reached at a boundary, the state returns to SEARCH on that edge and active<=0.
  - That byte is not presented: no strobe, data_out holds, valid_out<=0.
  - bc_cnt and los_cnt clear on exit.
- Not defined: los_cnt logic is absent and ACTIVE is sticky until reset.

Test Plan:
- Reset: reset=0 for 3 cycles with random data_in -> data_out=00, valid_out=0, active=0, byte_strobe=0 throughout.
- Lock, COM_COUNT=4: 3 junk bits 101, then 4x BC, then 8'h5A, 8'hBC -> active rises after the 4th BC's last bit.
  - Strobe with data_out=5A, valid_out=1.
  - 8 cycles later, a strobe with data_out=BC, valid_out=0.
- Failed alignment: BC, BC, 8'h3C, then 4x BC, then 8'hA5 -> active stays 0 through the 3C.
  - Lock is reached only after the later 4 BCs; the first strobe carries A5 with valid_out=1.
- Data stream in ACTIVE: 00,01,...,0F MSB-first -> 16 strobes exactly 8 cycles apart, each carrying the matching value, all valid_out=1.
  - data_out is held stable between strobes.
- Reset mid-byte: in ACTIVE, reset=0 after 4 bits of 8'hF0 -> next cycle all outputs are 0 and state is SEARCH.
  - A fresh COM_COUNT BC sequence is needed to relock.
- SP_LOSS_OF_SYNC_EN, LOS_COUNT=4: in ACTIVE, send 3x 00, then 11, then 4x 00 -> the first three 00s strobe with valid_out=1, then 11 strobes.
  - The fourth 00 of the second run drops active to 0 with no strobe.
  - Without the macro, all 8 bytes strobe and active stays 1.
